// File: rtl/rr_channel_arbiter_pkg.sv
// Shared types and constants for the round-robin channel arbiter.
// Covers the output-slot state encoding, the requester index type for the
// default configuration, and the statistics counter width and helper.
package rr_channel_arbiter_pkg;

  localparam int ARB_N_REQ_DEF = 4;
  localparam int ARB_IDX_W_DEF = $clog2(ARB_N_REQ_DEF);
  localparam int ARB_CNT_WIDTH = 16;

  typedef logic [ARB_IDX_W_DEF-1:0] arb_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  localparam logic [ARB_CNT_WIDTH-1:0] ARB_CNT_MAX = {ARB_CNT_WIDTH{1'b1}};

  // Saturating increment used by the per-requester grant counters
  function automatic logic [ARB_CNT_WIDTH-1:0] sat_inc(input logic [ARB_CNT_WIDTH-1:0] v);
    return (v == ARB_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_channel_arbiter_pick.sv
// Combinational rotating-priority picker: scans the request vector upward
// from the start pointer, wrapping at N_REQ-1, and returns the first set bit
// as a one-hot grant plus its index and an any-request flag.
module rr_priority_pick
  import rr_channel_arbiter_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int IDX_W = $clog2(N_REQ);

  int raw;
  int pos;

  // First requester at or after ptr (with wrap) wins; nothing set gives grant 0
  always_comb begin
    grant = {N_REQ{1'b0}};
    idx   = {IDX_W{1'b0}};
    any   = 1'b0;
    raw   = 0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      raw = int'(ptr) + k;
      pos = (raw >= N_REQ) ? raw - N_REQ : raw;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin arbiter sharing one registered ready/valid output slot among
// N_REQ requesters. The slot reloads in the same cycle it drains, so a
// non-stalling consumer sees one transfer per cycle. The pointer advances
// only on an input handshake, to the requester after the winner.
// Optional build macro ARB_STATS_EN adds per-requester saturating grant
// counters (grant_cnt) with a synchronous clear (stats_clr).
module rr_channel_arbiter
  import rr_channel_arbiter_pkg::*;
#(
  parameter int N_REQ      = ARB_N_REQ_DEF,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                in_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]     in_data,
  output logic [N_REQ-1:0]                in_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [$clog2(N_REQ)-1:0]        out_id,
`ifdef ARB_STATS_EN
  output logic [N_REQ*ARB_CNT_WIDTH-1:0]  grant_cnt,
  input  logic                            stats_clr,
`endif
  input  logic                            out_ready
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [N_REQ-1:0]       grant;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_any;
  logic                   can_load;
  logic                   in_hs;

  rr_priority_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign can_load  = (state == ST_EMPTY) | out_ready;
  assign in_ready  = grant & {N_REQ{can_load}};
  assign in_hs     = win_any & can_load;
  assign out_valid = (state == ST_FULL);

  // Slot FSM: load on handshake (even while draining), empty on drain-only, else hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      rr_ptr   <= {IDX_W{1'b0}};
      out_data <= {DATA_WIDTH{1'b0}};
      out_id   <= {IDX_W{1'b0}};
    end else if (in_hs) begin
      state    <= ST_FULL;
      out_data <= in_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
      out_id   <= win_idx;
      rr_ptr   <= (win_idx == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : win_idx + IDX_W'(1);
    end else if (state == ST_FULL && out_ready) begin
      state <= ST_EMPTY;
    end else begin
      state <= state;
    end
  end

`ifdef ARB_STATS_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
    logic [ARB_CNT_WIDTH-1:0] cnt;

    // Per-requester handshake counter; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= {ARB_CNT_WIDTH{1'b0}};
      end else if (stats_clr) begin
        cnt <= {ARB_CNT_WIDTH{1'b0}};
      end else if (in_valid[gi] && in_ready[gi]) begin
        cnt <= sat_inc(cnt);
      end else begin
        cnt <= cnt;
      end
    end

    assign grant_cnt[gi*ARB_CNT_WIDTH +: ARB_CNT_WIDTH] = cnt;
  end
`endif

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Directed bench for rr_channel_arbiter with a reference model and a
// scoreboard queue holding the expected content of the output slot.
module tb_rr_channel_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            out_ready;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic            stats_clr;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  logic m_full;
  int   m_ptr;

  always #5 clk = ~clk;

  rr_channel_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
`ifdef ARB_STATS_EN
    .grant_cnt (grant_cnt),
    .stats_clr (stats_clr),
`endif
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference rotating priority: rotate a doubled copy of the valid vector
  function automatic logic [N-1:0] m_grant(input logic [N-1:0] v, input int ptr);
    logic [2*N-1:0] dbl;
    dbl = {v, v} >> ptr;
    for (int k = 0; k < N; k++)
      if (dbl[k]) return N'(1) << ((ptr + k) % N);
    return '0;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = {$urandom, $urandom};
  endtask

  // Drive one cycle of inputs, check against the model, then advance the model
  task automatic step(input logic [N-1:0] v, input logic ordy);
    logic [N-1:0] eg;
    int w;
    exp_t e;
    in_valid  = v;
    out_ready = ordy;
    #1;
    eg = (!m_full || ordy) ? m_grant(v, m_ptr) : '0;
    chk("in_ready", 64'(in_ready), 64'(eg));
    chk("out_valid", 64'(out_valid), 64'(m_full));
    chk("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
    if (m_full) begin
      chk("out_id", 64'(out_id), 64'(sb[0].id));
      chk("out_data", out_data, sb[0].data);
    end
    @(posedge clk);
    if (m_full && ordy) begin
      void'(sb.pop_front());
      m_full = 1'b0;
    end
    if (eg != '0) begin
      w = 0;
      for (int k = 0; k < N; k++) if (eg[k]) w = k;
      e.id   = 2'(w);
      e.data = in_data[w*DW +: DW];
      sb.push_back(e);
      m_full = 1'b1;
      m_ptr  = (w + 1) % N;
    end
    @(negedge clk);
  endtask

  initial begin
    int seq[5];
    logic [DW-1:0] saved;
    seq = '{0, 1, 2, 3, 0};
    rst = 1'b0;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    m_full = 1'b0;
    m_ptr  = 0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    rst = 1'b1;

    // Idle
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);

    // Single requester 2
    rand_data();
    in_data[2*DW +: DW] = 64'hA5;
    step(4'b0100, 1'b1);
    chk("single_id", 64'(out_id), 64'd2);
    chk("single_data", out_data, 64'hA5);
    chk("single_ptr", 64'(dut.rr_ptr), 64'd3);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Wrap and skip from pointer 3
    rand_data();
    step(4'b0011, 1'b1);
    chk("wrap_id0", 64'(out_id), 64'd0);
    step(4'b0011, 1'b1);
    chk("wrap_id1", 64'(out_id), 64'd1);
    chk("wrap_ptr", 64'(dut.rr_ptr), 64'd2);

    // Reset while the slot is full discards it
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ptr", 64'(dut.rr_ptr), 64'd0);
    sb.delete();
    m_full = 1'b0;
    m_ptr  = 0;
    @(negedge clk);
    rst = 1'b1;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // All valid, no backpressure: 0,1,2,3,0,1 back to back
    for (int k = 0; k < 6; k++) begin
      if (k >= 1) begin
        chk("seq_id", 64'(out_id), 64'(seq[k-1]));
        chk("seq_valid", 64'(out_valid), 64'd1);
      end
      rand_data();
      step(4'b1111, 1'b1);
    end
    chk("seq_last_id", 64'(out_id), 64'd1);

    // Backpressure holding id1, then drain+load of id2 in one cycle
    saved = out_data;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      step(4'b1111, 1'b0);
      chk("bp_data_stable", out_data, saved);
      chk("bp_id_stable", 64'(out_id), 64'd1);
    end
    step(4'b1111, 1'b1);
    chk("bp_release_id", 64'(out_id), 64'd2);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Random valid patterns, dropped valids and stalls
    for (int k = 0; k < 80; k++) begin
      rand_data();
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

`ifdef ARB_STATS_EN
    stats_clr = 1'b1;
    step(4'b0000, 1'b1);
    stats_clr = 1'b0;
    chk("cnt_clr", 64'(grant_cnt[15:0]), 64'd0);
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    repeat (20000) @(negedge clk);
    chk("cnt_20000", 64'(grant_cnt[15:0]), 64'd20000);
    repeat (45600) @(negedge clk);
    chk("cnt_sat", 64'(grant_cnt[15:0]), 64'hFFFF);
    chk("cnt_other", 64'(grant_cnt[31:16]), 64'd0);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    in_valid  = 4'b0000;
    chk("cnt_clr_wins", 64'(grant_cnt[15:0]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
